// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requesters share one write-first RAM port with lockable grants; define MEM_ARB_ROUND_ROBIN_EN for round-robin, otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
    parameter int BYTES = 4,
    parameter int WIDTH = BYTES * 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_addr,
    input  logic [BYTES-1:0] req0_we,
    input  logic [WIDTH-1:0] req0_wdata,
    input  logic             req0_lock,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_addr,
    input  logic [BYTES-1:0] req1_we,
    input  logic [WIDTH-1:0] req1_wdata,
    input  logic             req1_lock,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] ram_addr,
    output logic [BYTES-1:0] ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);
    if (WIDTH != BYTES * 8) begin : g_width_check
        $error("mem_port_arbiter: WIDTH must equal BYTES*8");
    end
    typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_t;
    state_t state;
    logic pend, owner, pick1, go0, go1, xfer, lock;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr;
    always_comb pick1 = req1_valid && (!req0_valid || ptr);
`else
    always_comb pick1 = req1_valid && !req0_valid;
`endif
    always_comb begin
        go0 = !rst && req0_valid && (state == LOCK0 || (state == OPEN && !pick1));
        go1 = !rst && req1_valid && (state == LOCK1 || (state == OPEN && pick1));
        xfer = go0 || go1;
        lock = go1 ? req1_lock : req0_lock;
        req0_ready = go0;
        req1_ready = go1;
        ram_addr = go1 ? req1_addr : req0_addr;
        ram_wdata = go1 ? req1_wdata : req0_wdata;
        ram_we = go1 ? req1_we : go0 ? req0_we : '0;
        rsp0_valid = !rst && pend && !owner;
        rsp1_valid = !rst && pend && owner;
        rsp0_data = ram_rdata;
        rsp1_data = ram_rdata;
    end
    // owner tag travels with the one-cycle RAM latency so the response follows its issuer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OPEN;
            pend <= 1'b0;
            owner <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr <= 1'b0;
`endif
        end else begin
            pend <= xfer;
            owner <= go1;
            if (xfer) state <= !lock ? OPEN : go1 ? LOCK1 : LOCK0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (xfer) ptr <= go0;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against a write-first RAM model.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, d0 = '0, d1 = '0;
    logic [3:0] w0 = '0, w1 = '0;
    logic r0, r1, s0, s1;
    logic [31:0] q0, q1, ram_addr, ram_wdata, ram_rdata, word;
    logic [3:0] ram_we;
    logic [31:0] mem [0:255];
    int n_vec = 0, n_err = 0;
    logic exp1;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_addr(a0), .req0_we(w0), .req0_wdata(d0), .req0_lock(l0),
        .rsp0_valid(s0), .rsp0_data(q0),
        .req1_valid(v1), .req1_ready(r1), .req1_addr(a1), .req1_we(w1), .req1_wdata(d1), .req1_lock(l1),
        .rsp1_valid(s1), .rsp1_data(q1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        word = mem[ram_addr[7:0]];
        for (int b = 0; b < 4; b++) if (ram_we[b]) word[b*8 +: 8] = ram_wdata[b*8 +: 8];
        mem[ram_addr[7:0]] <= word;
        ram_rdata <= word;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        settle;
        check("rst_ready0", r0, 0);
        v0 = 1; w0 = 4'hf; v1 = 1;
        settle;
        check("rst_ready0_v", r0, 0);
        check("rst_ready1_v", r1, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_rsp0", s0, 0);
        check("rst_rsp1", s1, 0);
        tick; tick;
        rst = 0; v0 = 0; v1 = 0; w0 = 0;
        settle;
        check("post_rst_rsp", {s0, s1}, 0);
        tick;
        // preload via full-word writes
        v0 = 1; a0 = 32'h10; w0 = 4'hf; d0 = 32'hdeadbeef;
        settle;
        check("wr_ready0", r0, 1);
        check("wr_ram_we", ram_we, 4'hf);
        check("wr_ram_addr", ram_addr, 32'h10);
        tick;
        check("wr_rsp0", s0, 1);
        check("wr_rsp0_data", q0, 32'hdeadbeef);
        a0 = 32'h4; d0 = 32'h11223344;
        settle;
        check("wr2_ready0", r0, 1);
        tick;
        check("wr2_rsp0_data", q0, 32'h11223344);
        a0 = 32'h10; w0 = 0; d0 = 0;
        settle;
        check("rd_ready0", r0, 1);
        check("rd_ram_we", ram_we, 0);
        tick;
        v0 = 0;
        check("rd_rsp0", s0, 1);
        check("rd_rsp0_data", q0, 32'hdeadbeef);
        check("rd_rsp1", s1, 0);
        v1 = 1; a1 = 32'h4; w1 = 4'b0010; d1 = 32'h0000ab00;
        settle;
        check("bw_ready1", r1, 1);
        check("bw_ram_we", ram_we, 4'b0010);
        check("bw_ram_wdata", ram_wdata, 32'h0000ab00);
        tick;
        check("bw_rsp1", s1, 1);
        check("bw_rsp0", s0, 0);
        check("bw_rsp1_data", q1, 32'h1122ab44);
        w1 = 0; d1 = 0;
        settle;
        check("bw_rd_ready1", r1, 1);
        tick;
        check("bw_rd_rsp1", s1, 1);
        check("bw_rd_data", q1, 32'h1122ab44);
        v0 = 1; a0 = 32'h10;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp1 = i[0];
`else
            exp1 = 0;
`endif
            settle;
            check($sformatf("cont%0d_ready0", i), r0, !exp1);
            check($sformatf("cont%0d_ready1", i), r1, exp1);
            check($sformatf("cont%0d_addr", i), ram_addr, exp1 ? 32'h4 : 32'h10);
            tick;
            check($sformatf("cont%0d_rsp", i), {s0, s1}, exp1 ? 2'b01 : 2'b10);
            check($sformatf("cont%0d_data", i), exp1 ? q1 : q0, exp1 ? 32'h1122ab44 : 32'hdeadbeef);
        end
        v0 = 0; l1 = 1;
        settle;
        check("lk1_ready1", r1, 1);
        tick;
        v0 = 1;
        for (int j = 0; j < 3; j++) begin
            l1 = (j < 2);
            settle;
            check($sformatf("lk1_%0d_ready0", j), r0, 0);
            check($sformatf("lk1_%0d_ready1", j), r1, 1);
            tick;
            check($sformatf("lk1_%0d_rsp1", j), s1, 1);
        end
        v1 = 0; l1 = 0;
        settle;
        check("unlock_ready0", r0, 1);
        tick;
        check("unlock_rsp0", s0, 1);
        v0 = 1; l0 = 1;
        settle;
        check("lk0_ready0", r0, 1);
        tick;
        l0 = 0; v1 = 1;
        settle;
        check("lk0_ready0_held", r0, 1);
        check("lk0_ready1", r1, 0);
        tick;
        v0 = 0; v1 = 1; l1 = 1;
        settle;
        check("pre_rst_ready1", r1, 1);
        tick;
        rst = 1; v1 = 0; l1 = 0; v0 = 1; w0 = 4'hf; d0 = 32'h0;
        settle;
        check("midrst_rsp1", s1, 0);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_ready0", r0, 0);
        tick;
        rst = 0; w0 = 0;
        settle;
        check("after_rst_rsp", {s0, s1}, 0);
        check("after_rst_open", r0, 1);
        tick;
        v0 = 0;
        check("after_rst_rsp0", s0, 1);
        check("after_rst_data", q0, 32'hdeadbeef);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter BYTES, default 4, giving the bytes per memory word.
REQ-002 The block SHALL have parameter WIDTH, default BYTES*8, giving the word/address width; WIDTH != BYTES*8 SHALL fail an elaboration assertion.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have, per requester n in {0,1}, port req<n>_valid  input  1  request present.
REQ-006 The block SHALL have, per requester, port req<n>_ready  output  1  request accepted this cycle.
REQ-007 The block SHALL have, per requester, port req<n>_addr  input  WIDTH  word address.
REQ-008 The block SHALL have, per requester, port req<n>_we  input  BYTES  byte write enables; all-zero means read.
REQ-009 The block SHALL have, per requester, port req<n>_wdata  input  WIDTH  write data.
REQ-010 The block SHALL have, per requester, port req<n>_lock  input  1  hold grant after this transfer.
REQ-011 The block SHALL have, per requester, port rsp<n>_valid  output  1  response data valid.
REQ-012 The block SHALL have, per requester, port rsp<n>_data  output  WIDTH  response data.
REQ-013 The block SHALL have port ram_addr  output  WIDTH  to memory port A address.
REQ-014 The block SHALL have port ram_we  output  BYTES  to memory port A byte enables.
REQ-015 The block SHALL have port ram_wdata  output  WIDTH  to memory port A write data.
REQ-016 The block SHALL have port ram_rdata  input  WIDTH  from memory port A registered read data, write-first.

Function
REQ-017 A transfer on requester n SHALL occur in a cycle where req<n>_valid and req<n>_ready are both 1; at most one requester SHALL be ready per cycle.
REQ-018 req<n>_ready SHALL be combinational: 1 iff req<n>_valid is 1 and n wins arbitration this cycle.
REQ-019 In the transfer cycle, ram_addr, ram_we and ram_wdata SHALL equal the winner's req fields; with no transfer, ram_we SHALL be 0 and ram_addr/ram_wdata SHALL be don't-care.
REQ-020 Every accepted transfer, read or write, SHALL produce exactly one response: rsp<n>_valid=1 for one cycle, exactly one cycle after acceptance, with rsp<n>_data=ram_rdata.
REQ-021 The block SHALL hold a registered owner tag so that the response goes to the requester that issued it, even if the grant has since changed; the other rsp_valid SHALL be 0.
REQ-022 Back-to-back transfers SHALL be sustained at 1 per cycle; no bubble is allowed between requesters.
REQ-023 The FSM SHALL have states OPEN, LOCK0 and LOCK1.
REQ-024 In OPEN, arbitration SHALL be per the Configuration section.
REQ-025 In LOCKn, only requester n SHALL be eligible; the other requester SHALL see ready=0 regardless of its valid.
REQ-026 An accepted transfer from n with req<n>_lock=1 SHALL move the FSM to LOCKn; an accepted transfer in LOCKn with lock=0 SHALL move it to OPEN; no transfer SHALL leave the state unchanged.
REQ-027 rsp_data for a write SHALL be the post-write word, as provided by the write-first memory; the block SHALL not modify it.
REQ-028 Simultaneous valid from both requesters in OPEN SHALL grant exactly one; the loser SHALL keep its request stable, and the block SHALL not drop it.

Reset
REQ-029 While rst=1: FSM SHALL be OPEN, owner tag invalid, rsp0_valid=rsp1_valid=0, ram_we=0, req0_ready=req1_ready=0, and round-robin pointer (if present) = requester 0.
REQ-030 A transfer whose response would fall in a reset cycle SHALL be discarded; no rsp_valid SHALL appear in the first cycle after rst deasserts.

Configuration
REQ-031 The macro MEM_ARB_ROUND_ROBIN_EN SHALL select the OPEN-state arbitration policy.
REQ-032 With MEM_ARB_ROUND_ROBIN_EN defined, a 1-bit priority pointer SHALL favour the requester not most recently granted; on contention the favoured one wins, and the pointer SHALL update on every transfer.
REQ-033 Without MEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention, and no pointer register SHALL exist.

Verification
REQ-034 Read: req0 read addr 0x10 with memory[0x10]=0xDEADBEEF -> ready0=1 in cycle T; rsp0_valid=1 and rsp0_data=0xDEADBEEF in T+1; rsp1_valid=0.
REQ-035 Byte write: req1 we=4'b0010, wdata=0x0000AB00, addr 0x4 over word 0x11223344 -> rsp1_data=0x1122AB44 at T+1; a subsequent read returns 0x1122AB44.
REQ-036 Contention, 4 cycles, both valid -> with the macro, grants 0,1,0,1; without it, grants 0,0,0,0 and ready1=0.
REQ-037 Lock: req1 transfers with lock=1, then req0 valid plus 3 more req1 transfers, the last with lock=0 -> ready0=0 throughout; req0 is granted in the cycle after the unlock transfer.
REQ-038 Reset mid-operation: rst=1 in the cycle after an accepted read -> no rsp_valid for that read, FSM returns to OPEN, ram_we=0.
